alu_issue_sequencer: RTL and testbench

- Clocked, parametrised successor to the combinational/delay-based ALU operand-steering block.
- Accepts one decoded instruction per handshake: opcode, destination field and two source operand values.
- Drives the ALU operands and opcode, then waits a programmable number of ALU latency cycles with a counter.
- Captures the result and performs a handshaked register-file write-back.
- Sits between decode/register read and the register file; replaces fixed simulation delays with cycle-accurate sequencing.

---
 rtl/alu_issue_sequencer_pkg.sv | 40 ++++
 rtl/alu_issue_sequencer_lat_counter.sv | 34 +++
 rtl/alu_issue_sequencer.sv | 155 +++++++++++++++
 tb/tb_alu_issue_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_sequencer_pkg.sv
// Shared definitions for the ALU issue sequencer.
//   - Default datapath and opcode widths. They match the global WORD_SIZE and
//     OP_SIZE defines used by the rest of the core.
//   - Sequencer state encoding.
//   - Opcode constants and a helper for building a no-write-back mask.
package alu_issue_sequencer_pkg;

  localparam int WORD_SIZE_DEF = 16;
  localparam int OP_SIZE_DEF   = 4;

  // Width of the ALU latency counter. ALU_LAT must be in 1..15.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } seq_state_t;

  // Opcode map shared with decode. CMP and NOP retire without a write.
  localparam logic [OP_SIZE_DEF-1:0] OP_NOP = 4'h0;
  localparam logic [OP_SIZE_DEF-1:0] OP_ADD = 4'h1;
  localparam logic [OP_SIZE_DEF-1:0] OP_SUB = 4'h2;
  localparam logic [OP_SIZE_DEF-1:0] OP_CMP = 4'h3;
  localparam logic [OP_SIZE_DEF-1:0] OP_AND = 4'h4;
  localparam logic [OP_SIZE_DEF-1:0] OP_OR  = 4'h5;
  localparam logic [OP_SIZE_DEF-1:0] OP_XOR = 4'h6;

  // One-hot mask bit for an opcode. OR these together to build NOWB_MASK,
  // e.g. nowb_bit(OP_CMP) | nowb_bit(OP_NOP).
  function automatic logic [2**OP_SIZE_DEF-1:0] nowb_bit(
    input logic [OP_SIZE_DEF-1:0] op
  );
    logic [2**OP_SIZE_DEF-1:0] m;
    m     = '0;
    m[op] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/alu_issue_sequencer_lat_counter.sv
// alu_lat_counter: loadable down-counter that times the ALU latency.
//   i_clk      clock, rising edge
//   i_rst_n    asynchronous active-low reset (clears the count)
//   i_load     load i_load_val (this takes priority over decrement)
//   i_load_val value to load
//   i_dec      decrement by one
//   o_count    current count
//   o_zero     count is zero
module alu_lat_counter
  import alu_issue_sequencer_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_cnt <= '0;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_dec)  r_cnt <= r_cnt - 1'b1;
  end

  assign o_count = r_cnt;
  assign o_zero  = (r_cnt == '0);

endmodule

// File: rtl/alu_issue_sequencer.sv
// alu_issue_sequencer: clocked operand-steering and write-back sequencer.
// It accepts one decoded instruction per handshake and drives registered
// operands and the opcode to the ALU. It waits ALU_LAT cycles, captures
// alu_out, then performs a handshaked register-file write. Opcodes flagged
// in NOWB_MASK retire without a write. So does a write to r0 when ZERO_RO=1.
// Ports:
//   i_tclk, i_rst_n               clock (rising edge), async active-low reset
//   i_issue_valid/o_issue_ready   issue handshake (ready only in IDLE)
//   i_sel, i_data1_out..3_out     opcode, destination field, operands A/B
//   o_alu_data_1/2, o_alu_op      registered ALU operands and opcode
//   i_alu_out                     ALU result
//   o_reg_on/o_reg_w/o_reg_addr/
//   o_reg_data_in, i_wb_ready     register-file write-back handshake
//   o_done                        one-cycle retire pulse
//   o_busy                        high outside IDLE
module alu_issue_sequencer
  import alu_issue_sequencer_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int OP_SIZE   = OP_SIZE_DEF,
  parameter int ADDR_W    = 4,
  parameter int ALU_LAT   = 2,
  parameter logic [2**OP_SIZE-1:0] NOWB_MASK = '0,
  parameter bit ZERO_RO   = 1'b1
) (
  input  logic                 i_tclk,
  input  logic                 i_rst_n,
  input  logic                 i_issue_valid,
  output logic                 o_issue_ready,
  input  logic [OP_SIZE-1:0]   i_sel,
  input  logic [WORD_SIZE-1:0] i_data1_out,
  input  logic [WORD_SIZE-1:0] i_data2_out,
  input  logic [WORD_SIZE-1:0] i_data3_out,
  output logic [WORD_SIZE-1:0] o_alu_data_1,
  output logic [WORD_SIZE-1:0] o_alu_data_2,
  output logic [OP_SIZE-1:0]   o_alu_op,
  input  logic [WORD_SIZE-1:0] i_alu_out,
  output logic                 o_reg_on,
  output logic                 o_reg_w,
  output logic [ADDR_W-1:0]    o_reg_addr,
  output logic [WORD_SIZE-1:0] o_reg_data_in,
  input  logic                 i_wb_ready,
  output logic                 o_done,
  output logic                 o_busy
);

  // The counter starts at ALU_LAT-1, so it reaches zero on the edge where the
  // result is valid. That edge is exactly ALU_LAT edges after accept.
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(ALU_LAT - 1);

  seq_state_t r_state, w_state_nxt;

  logic                 w_accept, w_sample, w_wb_fire;
  logic [CNT_W-1:0]     w_cnt;
  logic                 w_cnt_zero;
  logic [ADDR_W-1:0]    w_addr;
  logic                 w_nowb;

  logic [WORD_SIZE-1:0] r_alu_a, r_alu_b, r_wdata;
  logic [OP_SIZE-1:0]   r_alu_op;
  logic [ADDR_W-1:0]    r_addr;
  logic                 r_nowb, r_reg_on, r_reg_w, r_done;

  // Only the low ADDR_W bits of the destination field select a register.
  assign w_addr = i_data1_out[ADDR_W-1:0];
  assign w_nowb = NOWB_MASK[i_sel] | (ZERO_RO && (w_addr == '0));

  alu_lat_counter #(.W(CNT_W)) u_lat_cnt (
    .i_clk      (i_tclk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_accept),
    .i_load_val (LAT_LOAD),
    .i_dec      ((r_state == ST_EXEC) && !w_cnt_zero),
    .o_count    (w_cnt),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge i_tclk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_sample    = 1'b0;
    w_wb_fire   = 1'b0;
    case (r_state)
      ST_IDLE: if (i_issue_valid) begin
        w_accept    = 1'b1;
        w_state_nxt = ST_EXEC;
      end
      ST_EXEC: if (w_cnt == '0) begin
        w_sample    = 1'b1;
        w_state_nxt = r_nowb ? ST_IDLE : ST_WB;
      end
      ST_WB: if (i_wb_ready) begin
        w_wb_fire   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ALU operands and the opcode are not cleared on return to IDLE. They hold
  // their last values so the ALU inputs do not toggle when idle.
  always_ff @(posedge i_tclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_op <= '0;
      r_addr   <= '0;
      r_nowb   <= 1'b0;
      r_wdata  <= '0;
      r_reg_on <= 1'b0;
      r_reg_w  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_alu_a  <= i_data2_out;
        r_alu_b  <= i_data3_out;
        r_alu_op <= i_sel;
        r_addr   <= w_addr;
        r_nowb   <= w_nowb;
      end
      if (w_sample) begin
        r_wdata <= i_alu_out;
        if (r_nowb) begin
          r_done <= 1'b1;
        end else begin
          r_reg_on <= 1'b1;
          r_reg_w  <= 1'b1;
        end
      end
      if (w_wb_fire) begin
        r_reg_on <= 1'b0;
        r_reg_w  <= 1'b0;
        r_done   <= 1'b1;
      end
    end
  end

  assign o_issue_ready = (r_state == ST_IDLE);
  assign o_busy        = (r_state != ST_IDLE);
  assign o_alu_data_1  = r_alu_a;
  assign o_alu_data_2  = r_alu_b;
  assign o_alu_op      = r_alu_op;
  assign o_reg_on      = r_reg_on;
  assign o_reg_w       = r_reg_w;
  assign o_reg_addr    = r_addr;
  assign o_reg_data_in = r_wdata;
  assign o_done        = r_done;

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Directed bench for alu_issue_sequencer. Instance 0 uses ALU_LAT=2 and has
// CMP marked no-write. Instances 1 and 2 use ALU_LAT=1 and ALU_LAT=15.
// Each instance has an ALU model that outputs X except in the valid cycle.
module tb_alu_issue_sequencer;
  import alu_issue_sequencer_pkg::*;

  localparam int NI = 3;

  function automatic int lat_of(input int g);
    return (g == 0) ? 2 : (g == 1) ? 1 : 15;
  endfunction

  function automatic logic [15:0] alu_f(input logic [3:0] op,
                                        input logic [15:0] a, b);
    case (op)
      4'h1:    return a + b;
      4'h2:    return a - b;
      default: return a ^ b;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  sel;
  logic [15:0] d1, d2, d3;
  logic        iv [NI];
  logic        wbr[NI];
  logic        rdy[NI];
  logic        ron[NI];
  logic        rw [NI];
  logic        dn [NI];
  logic        bsy[NI];
  logic [15:0] a1 [NI];
  logic [15:0] a2 [NI];
  logic [15:0] aout[NI];
  logic [15:0] rdat[NI];
  logic [3:0]  aop [NI];
  logic [3:0]  radr[NI];

  int ntot = 0;
  int nfail = 0;
  int cyc = 0;
  int acc_q[$];
  logic [3:0]  wa_q[$];
  logic [15:0] wd_q[$];

  logic [3:0]  bs [3] = '{4'h1, 4'h2, 4'h4};
  logic [15:0] bd1[3] = '{16'h0003, 16'h0004, 16'h0006};
  logic [15:0] bd2[3] = '{16'h0001, 16'h0009, 16'h00F0};
  logic [15:0] bd3[3] = '{16'h0002, 16'h0004, 16'h0FF0};
  logic [15:0] bexp[3] = '{16'h0003, 16'h0005, 16'h0F00};

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    int k;
    alu_issue_sequencer #(
      .ALU_LAT   (lat_of(g)),
      .NOWB_MASK ((g == 0) ? 16'h0008 : 16'h0000),
      .ZERO_RO   (1'b1)
    ) u_dut (
      .i_tclk        (clk),
      .i_rst_n       (rst_n),
      .i_issue_valid (iv[g]),
      .o_issue_ready (rdy[g]),
      .i_sel         (sel),
      .i_data1_out   (d1),
      .i_data2_out   (d2),
      .i_data3_out   (d3),
      .o_alu_data_1  (a1[g]),
      .o_alu_data_2  (a2[g]),
      .o_alu_op      (aop[g]),
      .i_alu_out     (aout[g]),
      .o_reg_on      (ron[g]),
      .o_reg_w       (rw[g]),
      .o_reg_addr    (radr[g]),
      .o_reg_data_in (rdat[g]),
      .i_wb_ready    (wbr[g]),
      .o_done        (dn[g]),
      .o_busy        (bsy[g])
    );
    // k counts edges since accept. The result is valid only while k == ALU_LAT.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n)                k <= 0;
      else if (iv[g] && rdy[g])  k <= 1;
      else if (k != 0)           k <= (k >= lat_of(g)) ? 0 : k + 1;
    end
    assign aout[g] = (k == lat_of(g)) ? alu_f(aop[g], a1[g], a2[g]) : 16'hxxxx;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && iv[0] && rdy[0]) acc_q.push_back(cyc);
    if (rst_n && rw[0] && wbr[0]) begin
      wa_q.push_back(radr[0]);
      wd_q.push_back(rdat[0]);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue0(input logic [3:0] s, input logic [15:0] x1, x2, x3);
    sel = s; d1 = x1; d2 = x2; d3 = x3;
    iv[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
  endtask

  initial begin
    int n;
    sel = '0; d1 = '0; d2 = '0; d3 = '0;
    for (int g = 0; g < NI; g++) begin
      iv[g] = 1'b0;
      wbr[g] = 1'b1;
    end

    // Reset state
    repeat (2) tick();
    chk("rst_busy", bsy[0], 0);
    chk("rst_done", dn[0], 0);
    chk("rst_regw", rw[0], 0);
    chk("rst_a1", a1[0], 0);
    chk("rst_op", aop[0], 0);
    chk("rst_rdata", rdat[0], 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("ready_after_rst", rdy[0], 1);

    // Single ADD: r5 = 3 + 4
    issue0(4'h1, 16'h0005, 16'h0003, 16'h0004);
    chk("t1_a1", a1[0], 16'h0003);
    chk("t1_a2", a2[0], 16'h0004);
    chk("t1_op", aop[0], 4'h1);
    chk("t1_ready", rdy[0], 0);
    tick();
    chk("t1_regw_exec", rw[0], 0);
    tick();
    chk("t1_regw", rw[0], 1);
    chk("t1_regon", ron[0], 1);
    chk("t1_addr", radr[0], 5);
    chk("t1_data", rdat[0], 16'h0007);
    chk("t1_done_early", dn[0], 0);
    tick();
    chk("t1_regw_off", rw[0], 0);
    chk("t1_done", dn[0], 1);
    chk("t1_ready_done", rdy[0], 1);
    tick();
    chk("t1_done_pulse", dn[0], 0);

    // Write-back stall for 4 cycles; upper dest bits ignored, r9 = 0x20 - 0x8
    wbr[0] = 1'b0;
    issue0(4'h2, 16'hFF09, 16'h0020, 16'h0008);
    tick();
    tick();
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("stall%0d_regw", s), rw[0], 1);
      chk($sformatf("stall%0d_addr", s), radr[0], 9);
      chk($sformatf("stall%0d_data", s), rdat[0], 16'h0018);
      chk($sformatf("stall%0d_ready", s), rdy[0], 0);
      chk($sformatf("stall%0d_done", s), dn[0], 0);
      if (s < 3) tick();
    end
    wbr[0] = 1'b1;
    tick();
    chk("stall_done", dn[0], 1);
    chk("stall_regw_off", rw[0], 0);
    tick();

    // No-write opcode (CMP) then destination r0, both suppressed
    issue0(4'h3, 16'h0002, 16'h0005, 16'h0006);
    chk("cmp_regw0", rw[0], 0);
    tick();
    chk("cmp_regw1", rw[0], 0);
    chk("cmp_done_early", dn[0], 0);
    tick();
    chk("cmp_regw2", rw[0], 0);
    chk("cmp_done", dn[0], 1);
    chk("cmp_ready", rdy[0], 1);
    chk("cmp_data", rdat[0], 16'h0003);
    tick();
    chk("cmp_regw3", rw[0], 0);
    chk("cmp_done_pulse", dn[0], 0);

    issue0(4'h1, 16'h0010, 16'h0001, 16'h0001);
    tick();
    chk("r0_regw1", rw[0], 0);
    tick();
    chk("r0_regw2", rw[0], 0);
    chk("r0_done", dn[0], 1);
    chk("r0_data", rdat[0], 16'h0002);
    tick();
    chk("r0_regw3", rw[0], 0);

    // Back-to-back with issue_valid held high
    acc_q.delete(); wa_q.delete(); wd_q.delete();
    for (int i = 0; i < 3; i++) begin
      sel = bs[i]; d1 = bd1[i]; d2 = bd2[i]; d3 = bd3[i];
      iv[0] = 1'b1;
      n = 0;
      do begin
        tick();
        n++;
      end while (acc_q.size() < i + 1 && n < 10);
      chk($sformatf("b2b_acc%0d", i), acc_q.size(), i + 1);
    end
    iv[0] = 1'b0;
    repeat (6) tick();
    chk("b2b_gap01", (acc_q.size() == 3) ? acc_q[1] - acc_q[0] : -1, 4);
    chk("b2b_gap12", (acc_q.size() == 3) ? acc_q[2] - acc_q[1] : -1, 4);
    chk("b2b_nwr", wa_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("b2b_addr%0d", i), (wa_q.size() > i) ? {28'd0, wa_q[i]} : 32'hFFFF_FFFF,
          {28'd0, bd1[i][3:0]});
      chk($sformatf("b2b_data%0d", i), (wd_q.size() > i) ? {16'd0, wd_q[i]} : 32'hFFFF_FFFF,
          {16'd0, bexp[i]});
    end

    // Asynchronous reset mid-EXEC
    issue0(4'h1, 16'h0007, 16'h0002, 16'h0002);
    chk("ar_busy", bsy[0], 1);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_a1", a1[0], 0);
    chk("ar_op", aop[0], 0);
    chk("ar_busy0", bsy[0], 0);
    chk("ar_addr", radr[0], 0);
    chk("ar_regw", rw[0], 0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int s = 0; s < 4; s++) begin
      tick();
      chk($sformatf("ar_post%0d_regw", s), rw[0], 0);
      chk($sformatf("ar_post%0d_ready", s), rdy[0], 1);
    end
    issue0(4'h1, 16'h0008, 16'h1000, 16'h0234);
    tick();
    tick();
    chk("ar_next_regw", rw[0], 1);
    chk("ar_next_addr", radr[0], 8);
    chk("ar_next_data", rdat[0], 16'h1234);
    tick();
    chk("ar_next_done", dn[0], 1);

    // Latency sweep: ALU_LAT = 1 and 15
    sel = 4'h1; d1 = 16'h000A; d2 = 16'h0100; d3 = 16'h0023;
    iv[1] = 1'b1; iv[2] = 1'b1;
    tick();
    iv[1] = 1'b0; iv[2] = 1'b0;
    for (int m = 1; m <= 17; m++) begin
      tick();
      for (int g = 1; g < NI; g++) begin
        chk($sformatf("lat%0d_regw_t%0d", lat_of(g), m), rw[g], (m == lat_of(g)));
        chk($sformatf("lat%0d_done_t%0d", lat_of(g), m), dn[g], (m == lat_of(g) + 1));
        if (m == lat_of(g)) begin
          chk($sformatf("lat%0d_data", lat_of(g)), rdat[g], 16'h0123);
          chk($sformatf("lat%0d_addr", lat_of(g)), radr[g], 4'hA);
        end
      end
    end

    $display("%0d/%0d checks passed", ntot - nfail, ntot);
    $finish;
  end

endmodule
